// File: rtl/fmadiv_pkg.sv
// fmadiv_pkg: shared types and constants for the binary16 divider.
// Rounding modes take effect only when FMADIV_RNE_EN is defined.
package fmadiv_pkg;
  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_ROUND,
    S_DONE
  } state_e;

  localparam int BIAS      = 15;
  localparam int DIV_ITERS = 13;

  localparam logic [4:0]  EXP_MAX = 5'd31;
  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] INF     = 16'h7C00;
  localparam logic [15:0] MAXNORM = 16'h7BFF;

  localparam logic [1:0] RM_RZ  = 2'b00;
  localparam logic [1:0] RM_RNE = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  localparam int FLAG_NV = 3;
  localparam int FLAG_DZ = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_NX = 0;
endpackage

// File: rtl/fmadiv_if.sv
// fmadiv_if: operand/result valid-ready bundle for the divider.
// master drives operands and out_ready; slave is the divider.
interface fmadiv_if;
  import fmadiv_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [1:0]  roundmode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [3:0]  flags;

  modport master (
    output in_valid, x, y, roundmode, out_ready,
    input  in_ready, out_valid, quotient, flags
  );

  modport slave (
    input  in_valid, x, y, roundmode, out_ready,
    output in_ready, out_valid, quotient, flags
  );
endinterface

// File: rtl/fmadiv_round.sv
// fmadiv_round: normalise, round and pack the raw 13-bit quotient.
// Without FMADIV_RNE_EN every result truncates toward zero.
module fmadiv_round
  import fmadiv_pkg::*;
(
  input  logic [12:0]       q,
  input  logic              rem_nz,
  input  logic signed [6:0] e_in,
  input  logic              s,
  input  logic [1:0]        rm,
  output logic [15:0]       quotient,
  output logic [3:0]        flags
);
  logic [9:0] mant;
  logic [9:0] mant_r;
  logic guard;
  logic sticky;
  logic inc;
  logic carry;
  logic to_inf;
  logic signed [6:0] e_n;
  logic signed [6:0] e_r;

`ifndef FMADIV_RNE_EN
  logic unused_rm;
  assign unused_rm = ^rm;
`endif

  always_comb begin
    mant   = q[12] ? q[11:2] : q[10:1];
    guard  = q[12] ? q[1] : q[0];
    sticky = rem_nz | (q[12] & q[0]);
    e_n    = e_in + $signed({6'd0, q[12]});
`ifdef FMADIV_RNE_EN
    unique case (rm)
      RM_RNE:  inc = guard & (sticky | mant[0]);
      RM_RDN:  inc = (guard | sticky) & s;
      RM_RUP:  inc = (guard | sticky) & ~s;
      default: inc = 1'b0;
    endcase
    to_inf = (rm == RM_RNE)
           | ((rm == RM_RDN) & s)
           | ((rm == RM_RUP) & ~s);
`else
    inc    = 1'b0;
    to_inf = 1'b0;
`endif
    {carry, mant_r} = {1'b0, mant} + 11'(inc);
    e_r = e_n + $signed({6'd0, carry});
    flags = '0;
    flags[FLAG_NX] = guard | sticky;
    quotient = {s, e_r[4:0], mant_r};
    if (e_r >= 7'sd31) begin
      flags[FLAG_OF] = 1'b1;
      flags[FLAG_NX] = 1'b1;
      quotient = to_inf ? {s, INF[14:0]}
                        : {s, MAXNORM[14:0]};
    end else if (e_r <= 7'sd0) begin
      flags[FLAG_NX] = 1'b1;
      quotient = {s, 15'd0};
    end
  end
endmodule

// File: rtl/fmadiv.sv
// fmadiv: sequential binary16 divider, restoring radix-2, one bit/cycle.
// Define FMADIV_RNE_EN to honour roundmode; otherwise results truncate.
module fmadiv
  import fmadiv_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  fmadiv_if.slave io
);
  state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] rem_q, rem_d;
  logic [10:0] my_q, my_d;
  logic [12:0] q_q, q_d;
  logic signed [6:0] e_q, e_d;
  logic s_q, s_d;
  logic [1:0]  rm_q, rm_d;
  logic [15:0] quo_q, quo_d;
  logic [3:0]  flg_q, flg_d;

  logic [4:0]  ex, ey;
  logic        nan, dz, zq, s_in;
  logic        ge;
  logic [11:0] rem_nx;
  logic [15:0] r_quo;
  logic [3:0]  r_flg;

  assign ex   = io.x[14:10];
  assign ey   = io.y[14:10];
  assign s_in = io.x[15] ^ io.y[15];
  // subnormal inputs count as zero
  assign nan  = (ex == EXP_MAX) | (ey == EXP_MAX)
              | ((ex == 5'd0) & (ey == 5'd0));
  assign dz   = ~nan & (ey == 5'd0);
  assign zq   = ~nan & ~dz & (ex == 5'd0);

  assign io.in_ready  = (state_q == S_IDLE) & ~reset;
  assign io.out_valid = (state_q == S_DONE);
  assign io.quotient  = quo_q;
  assign io.flags     = flg_q;

  fmadiv_round u_round (
    .q        (q_q),
    .rem_nz   (|rem_q),
    .e_in     (e_q),
    .s        (s_q),
    .rm       (rm_q),
    .quotient (r_quo),
    .flags    (r_flg)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    my_d    = my_q;
    q_d     = q_q;
    e_d     = e_q;
    s_d     = s_q;
    rm_d    = rm_q;
    quo_d   = quo_q;
    flg_d   = flg_q;
    ge      = rem_q >= {1'b0, my_q};
    rem_nx  = ge ? rem_q - {1'b0, my_q} : rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (io.in_valid && io.in_ready) begin
          s_d     = s_in;
          rm_d    = io.roundmode;
          rem_d   = {2'b01, io.x[9:0]};
          my_d    = {1'b1, io.y[9:0]};
          e_d     = $signed({2'b00, ex})
                  - $signed({2'b00, ey})
                  + 7'(BIAS - 1);
          cnt_d   = '0;
          q_d     = '0;
          state_d = S_DONE;
          flg_d   = '0;
          unique case (1'b1)
            nan: begin
              quo_d = QNAN;
              flg_d[FLAG_NV] = 1'b1;
            end
            dz: begin
              quo_d = {s_in, INF[14:0]};
              flg_d[FLAG_DZ] = 1'b1;
            end
            zq:      quo_d = {s_in, 15'd0};
            default: state_d = S_DIV;
          endcase
        end
      end
      S_DIV: begin
        rem_d = rem_nx << 1;
        q_d   = {q_q[11:0], ge};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(DIV_ITERS - 1))
          state_d = S_ROUND;
      end
      S_ROUND: begin
        quo_d   = r_quo;
        flg_d   = r_flg;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (io.out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      my_q    <= '0;
      q_q     <= '0;
      e_q     <= '0;
      s_q     <= 1'b0;
      rm_q    <= '0;
      quo_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      my_q    <= my_d;
      q_q     <= q_d;
      e_q     <= e_d;
      s_q     <= s_d;
      rm_q    <= rm_d;
      quo_q   <= quo_d;
      flg_q   <= flg_d;
    end
  end
endmodule

// File: tb/tb_fmadiv.sv
// tb_fmadiv: self-checking bench for fmadiv with a rational-arithmetic model.
// Expectations follow FMADIV_RNE_EN when it is defined for the build.
module tb_fmadiv;
  logic clk = 1'b0;
  logic reset;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fmadiv_if bus();

  fmadiv dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  // exact quotient by integer division, then the binary16 rounding rules
  function automatic void ref_div(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  m,
    output logic [15:0] rq,
    output logic [3:0]  rf
  );
    int ea, eb, e, mant, ma, mb, qq;
    bit s, g, st, rnz, inc, up;
    logic [1:0] rm;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
`ifdef FMADIV_RNE_EN
    rm = m;
`else
    rm = 2'd0;
    if (m == 2'd3) rm = 2'd0;
`endif
    rf = 4'd0;
    if (ea == 31 || eb == 31 || (ea == 0 && eb == 0)) begin
      rq = 16'h7E00; rf = 4'b1000; return;
    end
    if (eb == 0) begin
      rq = {s, 15'h7C00}; rf = 4'b0100; return;
    end
    if (ea == 0) begin
      rq = {s, 15'h0000}; return;
    end
    ma  = 1024 + int'(a[9:0]);
    mb  = 1024 + int'(b[9:0]);
    qq  = (ma * 4096) / mb;
    rnz = ((ma * 4096) % mb) != 0;
    if (qq >= 4096) begin
      mant = (qq / 4) % 1024; g = (qq / 2) % 2;
      st = (qq % 2 == 1) || rnz; e = ea - eb + 15;
    end else begin
      mant = (qq / 2) % 1024; g = qq % 2;
      st = rnz; e = ea - eb + 14;
    end
    up = g | st;
    case (rm)
      2'd1:    inc = g && (st || (mant % 2 == 1));
      2'd2:    inc = up && s;
      2'd3:    inc = up && !s;
      default: inc = 1'b0;
    endcase
    mant = mant + int'(inc);
    if (mant == 1024) begin mant = 0; e = e + 1; end
    if (e >= 31) begin
      rf = 4'b0011;
      if (rm == 2'd1 || (rm == 2'd2 && s) || (rm == 2'd3 && !s))
        rq = {s, 15'h7C00};
      else
        rq = {s, 15'h7BFF};
    end else if (e <= 0) begin
      rf = 4'b0001; rq = {s, 15'h0000};
    end else begin
      rf = {3'b000, up}; rq = {s, 5'(e), 10'(mant)};
    end
  endfunction

  // drive one operation to completion; lat = -1 when out_valid never rises
  task automatic do_op(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  m,
    output logic [15:0] q,
    output logic [3:0]  f,
    output int          lat
  );
    int n;
    @(negedge clk);
    bus.x = a; bus.y = b; bus.roundmode = m;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.x = 16'($urandom); bus.y = 16'($urandom);
    bus.roundmode = 2'($urandom_range(0, 3));
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin lat = i; break; end
    end
    q = bus.quotient; f = bus.flags;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if ({bus.quotient, bus.flags} !== 20'h0) begin
      errors++;
      $display("FAIL reset_result got=%h/%b exp=0000/0000", bus.quotient, bus.flags);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_exact();
    logic [15:0] q; logic [3:0] f; int lat;
    do_op(16'h4000, 16'h3C00, 2'd0, q, f, lat);
    checks++;
    if ({q, f} !== {16'h4000, 4'h0}) begin
      errors++; $display("FAIL exact got=%h/%b exp=4000/0000", q, f);
    end
    checks++;
    if (lat !== 15) begin
      errors++; $display("FAIL exact_latency got=%0d exp=15", lat);
    end
  endtask

  task automatic test_rounding();
    logic [15:0] q, eq; logic [3:0] f; int lat;
    do_op(16'h4500, 16'h4200, 2'd0, q, f, lat);
    checks++;
    if ({q, f} !== {16'h3EAA, 4'h1}) begin
      errors++; $display("FAIL round_rz got=%h/%b exp=3eaa/0001", q, f);
    end
`ifdef FMADIV_RNE_EN
    eq = 16'h3EAB;
`else
    eq = 16'h3EAA;
`endif
    do_op(16'h4500, 16'h4200, 2'd1, q, f, lat);
    checks++;
    if ({q, f} !== {eq, 4'h1}) begin
      errors++; $display("FAIL round_rne got=%h/%b exp=%h/0001", q, f, eq);
    end
  endtask

  task automatic test_specials();
    logic [15:0] sx[4] = '{16'h0000, 16'hBC00, 16'h0000, 16'h7C00};
    logic [15:0] sy[4] = '{16'h0000, 16'h0000, 16'h4000, 16'h3C00};
    logic [15:0] sq[4] = '{16'h7E00, 16'hFC00, 16'h0000, 16'h7E00};
    logic [3:0]  sf[4] = '{4'b1000, 4'b0100, 4'b0000, 4'b1000};
    logic [15:0] q; logic [3:0] f; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(sx[i], sy[i], 2'($urandom_range(0, 3)), q, f, lat);
      checks++;
      if ({q, f} !== {sq[i], sf[i]}) begin
        errors++;
        $display("FAIL special%0d got=%h/%b exp=%h/%b", i, q, f, sq[i], sf[i]);
      end
      checks++;
      if (lat !== 1) begin
        errors++; $display("FAIL special%0d_latency got=%0d exp=1", i, lat);
      end
    end
  endtask

  task automatic test_range();
    logic [15:0] q, eq; logic [3:0] f; int lat;
    do_op(16'h7BFF, 16'h0400, 2'd0, q, f, lat);
    checks++;
    if ({q, f} !== {16'h7BFF, 4'b0011}) begin
      errors++; $display("FAIL overflow_rz got=%h/%b exp=7bff/0011", q, f);
    end
`ifdef FMADIV_RNE_EN
    eq = 16'h7C00;
`else
    eq = 16'h7BFF;
`endif
    do_op(16'h7BFF, 16'h0400, 2'd1, q, f, lat);
    checks++;
    if ({q, f} !== {eq, 4'b0011}) begin
      errors++; $display("FAIL overflow_rne got=%h/%b exp=%h/0011", q, f, eq);
    end
    do_op(16'h0400, 16'h7BFF, 2'd0, q, f, lat);
    checks++;
    if ({q, f} !== {16'h0000, 4'b0001}) begin
      errors++; $display("FAIL underflow got=%h/%b exp=0000/0001", q, f);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, q, eq; logic [3:0] f, ef; logic [1:0] m;
    int lat, elat;
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      m = 2'($urandom_range(0, 3));
      ref_div(a, b, m, eq, ef);
      elat = (a[14:10] == 5'd0 || a[14:10] == 5'd31 ||
              b[14:10] == 5'd0 || b[14:10] == 5'd31) ? 1 : 15;
      do_op(a, b, m, q, f, lat);
      checks++;
      if ({q, f} !== {eq, ef}) begin
        errors++;
        $display("FAIL rand %h/%h rm=%0d got=%h/%b exp=%h/%b", a, b, m, q, f, eq, ef);
      end
      checks++;
      if (lat !== elat) begin
        errors++; $display("FAIL rand_latency got=%0d exp=%0d", lat, elat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] q; logic [3:0] f; int n, lat;
    @(negedge clk);
    bus.x = 16'h4500; bus.y = 16'h4200; bus.roundmode = 2'd0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_timeout got=%b exp=1", bus.out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.quotient, bus.flags} !==
          {1'b1, 1'b0, 16'h3EAA, 4'h1}) begin
        errors++;
        $display("FAIL bp_hold%0d got=v%b r%b %h/%b exp=v1 r0 3eaa/0001",
                 i, bus.out_valid, bus.in_ready, bus.quotient, bus.flags);
      end
      bus.in_valid = 1'b1;
      bus.x = 16'($urandom); bus.y = 16'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release got=v%b r%b exp=v0 r1", bus.out_valid, bus.in_ready);
    end
    do_op(16'h4000, 16'h3C00, 2'd0, q, f, lat);
    checks++;
    if ({q, f} !== {16'h4000, 4'h0}) begin
      errors++; $display("FAIL bp_next got=%h/%b exp=4000/0000", q, f);
    end
  endtask

  task automatic test_reset_mid_div();
    logic [15:0] q; logic [3:0] f; int lat;
    @(negedge clk);
    bus.x = 16'h4500; bus.y = 16'h4200; bus.roundmode = 2'd0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_in_ready got=%b exp=0", bus.in_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.quotient, bus.flags} !==
        {1'b0, 1'b1, 16'h0000, 4'h0}) begin
      errors++;
      $display("FAIL mid_reset_state got=v%b r%b %h/%b exp=v0 r1 0000/0000",
               bus.out_valid, bus.in_ready, bus.quotient, bus.flags);
    end
    do_op(16'h4000, 16'h3C00, 2'd0, q, f, lat);
    checks++;
    if ({q, f} !== {16'h4000, 4'h0} || lat !== 15) begin
      errors++;
      $display("FAIL mid_reset_next got=%h/%b lat=%0d exp=4000/0000 lat=15", q, f, lat);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x         = 16'h0;
    bus.y         = 16'h0;
    bus.roundmode = 2'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_exact();
    test_rounding();
    test_specials();
    test_range();
    test_random();
    test_backpressure();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fmadiv.md
# fmadiv

Sequential half-precision (binary16) floating-point divider, the inverse-operation companion to the fma16 multiplier. It computes q = x / y by radix-2 restoring division of the 11-bit significands, one quotient bit per cycle, then rounds and packs the result. Sits beside the multiplier in the fma16 datapath behind a valid/ready handshake on both input and output.

## Interface
- No parameters; the format is fixed at binary16 (bias 15).
- clk  in  1  Rising-edge clock.
- reset  in  1  Synchronous, active-high.
- in_valid  in  1  Operands and roundmode are valid this cycle.
- in_ready  out  1  Divider is idle and can accept an operation; defined as (state==IDLE) & ~reset.
- x  in  16  Dividend.
- y  in  16  Divisor.
- roundmode  in  2  Rounding mode: 00 RZ, 01 RNE, 10 RM, 11 RP.
- out_valid  out  1  quotient and flags are valid.
- out_ready  in  1  Consumer accepts the result.
- quotient  out  16  Result.
- flags  out  4  [3] NV invalid, [2] DZ divide-by-zero, [1] OF overflow, [0] NX inexact.

## Operation
- FSM states:
  - IDLE: accept when in_valid & in_ready; latch sign, exponents, roundmode and significands {1,frac}.
  - DIV: 13 iterations.
  - ROUND: 1 cycle.
  - DONE: hold the result until out_ready.
- IDLE → DIV for normal operands; IDLE → DONE directly for specials. DIV → ROUND after 13 iterations. ROUND → DONE. DONE → IDLE when out_ready is high.
- Specials, resolved at accept; a subnormal input (exp 0) is treated as zero:
  - Either exponent is 31: result 0x7E00, NV.
  - 0/0: result 0x7E00, NV.
  - Nonzero/0: result {s,0x7C00}, DZ.
  - 0/nonzero: result {s,15'h0}, no flags.
- Sign s = x[15] ^ y[15].
- Division:
  - Remainder starts at mx (12-bit), divisor is my.
  - Each cycle: if rem ≥ my, then rem -= my and the quotient bit is 1; then rem <<= 1.
  - Produces q[12:0], where q[12] is the integer bit.
- Normalization:
  - If q[12]=1: mant = q[11:2], guard = q[1], sticky = q[0] | (rem≠0), e = ex − ey + 15.
  - Otherwise: mant = q[10:1], guard = q[0], sticky = (rem≠0), e = ex − ey + 14.
  - e is a 7-bit signed value.
- Rounding, with the increment rule per mode:
  - RNE: guard & (sticky | mant[0]).
  - RM: (guard | sticky) & s.
  - RP: (guard | sticky) & ~s.
  - RZ: none.
  - If the mantissa increment carries out, mant = 0 and e += 1.
  - NX = guard | sticky.
- Overflow (e ≥ 31 after rounding):
  - OF and NX are set.
  - Result is ±inf for RNE, and for RM/RP when the rounding direction is away from zero.
  - Otherwise the result is {s,0x7BFF}.
- Underflow (e ≤ 0): flush to {s,15'h0} and set NX. There is no underflow flag.
- quotient and flags are written only when entering DONE; they are stable while out_valid & ~out_ready.

## Timing
- Reset values: state IDLE, out_valid 0, quotient 0x0000, flags 0. in_ready is 0 during reset and 1 on the first cycle after reset deasserts.
- Normal latency:
  - Accept at edge k.
  - DIV spans edges k+1 … k+13.
  - ROUND at edge k+14.
  - out_valid is high from edge k+15.
- Special-operand latency: out_valid is high from edge k+1.
- Throughput: in_ready is low from the accepting edge until the cycle after the output handshake, so there is no same-cycle accept/release. Maximum rate is one operation per 16 cycles.
- Inputs presented while in_ready is low are ignored; x, y and roundmode need not be held after the accept.
- Reset asserted mid-operation, in any state, aborts it. The next edge restores all reset values and the in-flight result is discarded.
- out_ready while out_valid is low has no effect.

## Configuration
- FMADIV_RNE_EN:
  - Defined: roundmode is honoured as above.
  - Undefined: roundmode is ignored and every result uses RZ (round toward zero). NX is still reported; overflow always gives {s,0x7BFF}.

## Structure
- fmadiv_pkg holds:
  - The state enum.
  - Constants BIAS=15, QNAN=16'h7E00, INF=16'h7C00, MAXNORM=16'h7BFF.
  - The roundmode encodings.
  - The flag bit indices.
- One sub-module, fmadiv_round: purely combinational. It takes q, rem≠0, e, s and roundmode, and produces quotient and flags. The top level holds the FSM, iteration counter and remainder datapath.

## Test plan
- Exact quotient: 0x4000/0x3C00, RZ → 0x4000, flags 0; out_valid rises exactly 15 cycles after accept.
- Rounding: 0x4500/0x4200 (5/3) with RZ → 0x3EAA, NX. With FMADIV_RNE_EN and roundmode 01 → 0x3EAB, NX.
- Specials, each with out_valid 1 cycle after accept:
  - 0x0000/0x0000 → 0x7E00, NV.
  - 0xBC00/0x0000 → 0xFC00, DZ.
  - 0x0000/0x4000 → 0x0000, flags 0.
  - 0x7C00/0x3C00 → 0x7E00, NV.
- Range:
  - 0x7BFF/0x0400, RZ → 0x7BFF, OF|NX.
  - Same operands, RNE with the macro defined → 0x7C00, OF|NX.
  - 0x0400/0x7BFF → 0x0000, NX.
- Backpressure: hold out_ready low for 5 cycles after out_valid. quotient and flags stay stable, in_ready stays 0, and in_valid pulses in that window are ignored.
- Reset mid-DIV at iteration 6 → next cycle out_valid 0, in_ready 1. A following 0x4000/0x3C00 completes correctly.
